key_scan_entry: RTL and testbench
=================================

Name: key_scan_entry

Overview:
- Input-side counterpart of the six-digit seven-segment display path: scans a 4x4 matrix keypad, debounces each key and decodes it.
- Assembles a six-digit BCD value on Number_Sig, which feeds the display interface's Number_Sig input directly.
- Also emits per-key events and an "enter" strobe that downstream DDS/SPI control uses to commit a new setting.

Parameters:
- SCAN_DIV, 50000, CLK cycles per scan tick (1 ms at 50 MHz); minimum 2.
- DEBOUNCE_CNT, 20, consecutive matching scan-tick samples needed to accept a press or a release; minimum 1.
- REPEAT_TICKS, 200, scan ticks between auto-repeat events; used only when KEY_REPEAT_EN is defined.

Ports:
- CLK  input  1  system clock.
- RSTn  input  1  asynchronous active-low reset.
- Row_Sig  input  4  keypad rows; active-low, externally pulled up; asynchronous to CLK.
- Col_Sig  output  4  keypad column drive; exactly one bit low (driven column), the rest high.
- Key_Valid  output  1  one-CLK pulse per accepted key event.
- Key_Code  output  4  {row_idx[1:0], col_idx[1:0]} of the last accepted key; held between events.
- Number_Sig  output  24  six BCD digits; [23:20] is the most significant digit.
- Number_Done  output  1  one-CLK pulse when the enter key is accepted.

Behaviour:
- Reset (asynchronous, RSTn low), all outputs:
  - Col_Sig=4'b1110; Key_Valid=0; Key_Code=0; Number_Sig=0; Number_Done=0.
  - State SCAN, column index 0, all counters 0.
  - Deasserting RSTn mid-debounce or mid-hold restarts cleanly from SCAN.
- Synchronisation:
  - Row_Sig passes through a 2-flop synchroniser before any use.
  - Sampling happens only on a scan tick: a free-running counter 0..SCAN_DIV-1 ticks when it wraps.
- State SCAN:
  - On each tick, sample the synchronised rows.
  - All rows high: advance the column index 0->1->2->3->0 and update Col_Sig on the same edge.
  - Any row low: capture row_idx and col_idx, set match count=1, go to DEBOUNCE. Lowest-index low row wins.
- State DEBOUNCE (column held):
  - Each tick: captured row still low and no lower-index row low -> count+1; otherwise return to SCAN, same column.
  - When count reaches DEBOUNCE_CNT: on that tick edge, Key_Code<=captured code, Key_Valid pulses next cycle, then go to HOLD.
  - Latency from the first low sample to Key_Valid is (DEBOUNCE_CNT-1) ticks + 1 CLK.
- State HOLD (column held):
  - Release count increments on ticks where all rows are high; any low row resets it to 0.
  - At DEBOUNCE_CNT, advance the column and return to SCAN.
  - No Key_Valid while in HOLD, unless KEY_REPEAT_EN is defined.
- Number assembly, applied in the same cycle Key_Valid is high:
  - Codes 0x0-0x9: digit entry, Number_Sig <= {Number_Sig[19:0], code}. The most significant digit is discarded; this wrap is intended.
  - 0xA: clear, Number_Sig <= 0.
  - 0xB: backspace, Number_Sig <= {4'h0, Number_Sig[23:4]}.
  - 0xE: enter, Number_Done=1 for that cycle; Number_Sig unchanged.
  - 0xC, 0xD, 0xF: Key_Valid only, no number effect.
- Number_Sig always holds valid BCD.
- Key_Valid and Number_Done are never high for more than one consecutive cycle.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - In HOLD, while the same key stays low, Key_Valid re-pulses (same Key_Code, same number action) every REPEAT_TICKS ticks after acceptance.
  - Codes 0xA and 0xE never repeat.
  - Any tick with all rows high resets the repeat counter.
- Undefined: no repeat counter is present in the design; exactly one event per press.

Test Plan:
Bench uses SCAN_DIV=4, DEBOUNCE_CNT=3.
- Reset release, no keys pressed -> Col_Sig cycles 1110,1101,1011,0111,1110 with one step per 4 CLK; Key_Valid never asserts; Number_Sig=0.
- Press row1/col2 (code 0x6) held for 10 ticks, then released -> exactly one Key_Valid pulse with Key_Code=4'h6; Number_Sig=24'h000006; scanning resumes after 3 released ticks.
- Bounce: row0 low 1 tick, high 1 tick, low 1 tick -> no Key_Valid. Then held low 3 ticks -> one event.
- Enter sequence 1,2,3,4,5,6,7 then 0xB then 0xE:
  - after 7 -> Number_Sig=24'h234567;
  - after 0xB -> 24'h023456;
  - after 0xE -> one Number_Done pulse, value unchanged;
  - 0xA then -> Number_Sig=0.
- Rows 1 and 3 low together on column 0 -> Key_Code=4'h4 only. RSTn pulsed low during DEBOUNCE -> all outputs return to reset values immediately; no event is emitted.
- KEY_REPEAT_EN defined, REPEAT_TICKS=5, key 0x9 held for 16 ticks past acceptance -> 4 Key_Valid pulses total; Number_Sig=24'h009999.

Source files
------------

// File: rtl/key_scan_entry.sv
// key_scan_entry: 4x4 matrix keypad scanner with per-key debounce, key decode and six-digit
// BCD number assembly for the seven-segment display path.
//
// Optional feature: define KEY_REPEAT_EN to enable auto-repeat of held keys every
// REPEAT_TICKS scan ticks (clear 0xA and enter 0xE never repeat).
//
// Ports:
//   CLK          system clock
//   RSTn         asynchronous active-low reset
//   Row_Sig[3:0] keypad rows, active-low, asynchronous to CLK
//   Col_Sig[3:0] keypad column drive, one bit low
//   Key_Valid    one-CLK pulse per accepted key event
//   Key_Code     {row_idx, col_idx} of the last accepted key
//   Number_Sig   six BCD digits, [23:20] most significant
//   Number_Done  one-CLK pulse when the enter key (0xE) is accepted
module key_scan_entry #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CNT = 20,
  parameter int unsigned REPEAT_TICKS = 200
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [3:0]  Row_Sig,
  output logic [3:0]  Col_Sig,
  output logic        Key_Valid,
  output logic [3:0]  Key_Code,
  output logic [23:0] Number_Sig,
  output logic        Number_Done
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam int unsigned CntW = $clog2(DEBOUNCE_CNT + 1);

  if (SCAN_DIV < 2 || DEBOUNCE_CNT < 1 || REPEAT_TICKS < 1) begin : g_param_check
    $error("key_scan_entry: illegal parameter setting");
  end

  typedef enum logic [1:0] {StScan, StDebounce, StHold} state_e;

  // Row synchroniser; rows idle high thanks to the external pull-ups.
  logic [3:0] row_meta_q, row_sync_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= Row_Sig;
      row_sync_q <= row_meta_q;
    end
  end

  // Free-running scan-tick divider; the tick is the wrap cycle.
  logic [DivW-1:0] div_q;
  logic            tick;

  assign tick = (div_q == DivW'(SCAN_DIV - 1));

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Lowest-index low row has priority.
  logic       any_low;
  logic [1:0] low_idx;

  always_comb begin
    any_low = ~&row_sync_q;
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_sync_q[i]) low_idx = 2'(i);
    end
  end

  state_e          state_q;
  logic [1:0]      col_q;
  logic [1:0]      row_cap_q;
  logic [CntW-1:0] cnt_q;
  logic            key_valid_q;
  logic            number_done_q;
  logic [3:0]      key_code_q;
  logic [3:0]      scan_code;

  assign scan_code = {low_idx, col_q};

`ifdef KEY_REPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_TICKS + 1);
  logic [RepW-1:0] rep_q;
`endif

  // cnt_q is the match count in StDebounce and the release count in StHold.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q       <= StScan;
      col_q         <= 2'd0;
      row_cap_q     <= 2'd0;
      cnt_q         <= '0;
      key_valid_q   <= 1'b0;
      number_done_q <= 1'b0;
      key_code_q    <= 4'h0;
`ifdef KEY_REPEAT_EN
      rep_q         <= '0;
`endif
    end else begin
      key_valid_q   <= 1'b0;
      number_done_q <= 1'b0;
      if (tick) begin
        case (state_q)
          StScan: begin
            if (any_low) begin
              row_cap_q <= low_idx;
              if (DEBOUNCE_CNT == 1) begin
                key_code_q    <= scan_code;
                key_valid_q   <= 1'b1;
                number_done_q <= (scan_code == 4'hE);
                cnt_q         <= '0;
                state_q       <= StHold;
`ifdef KEY_REPEAT_EN
                rep_q         <= '0;
`endif
              end else begin
                cnt_q   <= CntW'(1);
                state_q <= StDebounce;
              end
            end else begin
              col_q <= col_q + 2'd1;
            end
          end
          StDebounce: begin
            if (any_low && low_idx == row_cap_q) begin
              if (cnt_q == CntW'(DEBOUNCE_CNT - 1)) begin
                key_code_q    <= scan_code;
                key_valid_q   <= 1'b1;
                number_done_q <= (scan_code == 4'hE);
                cnt_q         <= '0;
                state_q       <= StHold;
`ifdef KEY_REPEAT_EN
                rep_q         <= '0;
`endif
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end else begin
              // Bounce: rescan the same column.
              cnt_q   <= '0;
              state_q <= StScan;
            end
          end
          StHold: begin
            if (!any_low) begin
`ifdef KEY_REPEAT_EN
              rep_q <= '0;
`endif
              if (cnt_q == CntW'(DEBOUNCE_CNT - 1)) begin
                cnt_q   <= '0;
                col_q   <= col_q + 2'd1;
                state_q <= StScan;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end else begin
              cnt_q <= '0;
`ifdef KEY_REPEAT_EN
              if (!row_sync_q[row_cap_q]) begin
                if (rep_q == RepW'(REPEAT_TICKS - 1)) begin
                  rep_q <= '0;
                  if (key_code_q != 4'hA && key_code_q != 4'hE) key_valid_q <= 1'b1;
                end else begin
                  rep_q <= rep_q + 1'b1;
                end
              end else begin
                rep_q <= '0;
              end
`endif
            end
          end
          default: begin
            cnt_q   <= '0;
            state_q <= StScan;
          end
        endcase
      end
    end
  end

  // Number assembly acts on the cycle Key_Valid is high.
  logic [23:0] number_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      number_q <= 24'h0;
    end else if (key_valid_q) begin
      if (key_code_q <= 4'h9) begin
        number_q <= {number_q[19:0], key_code_q};
      end else if (key_code_q == 4'hA) begin
        number_q <= 24'h0;
      end else if (key_code_q == 4'hB) begin
        number_q <= {4'h0, number_q[23:4]};
      end
    end
  end

  assign Col_Sig     = ~(4'b0001 << col_q);
  assign Key_Valid   = key_valid_q;
  assign Key_Code    = key_code_q;
  assign Number_Sig  = number_q;
  assign Number_Done = number_done_q;

endmodule

// File: tb/tb_key_scan_entry.sv
`timescale 1ns/1ps
module tb_key_scan_entry;

  localparam int unsigned ScanDiv = 4;
  localparam int unsigned Deb     = 3;
  localparam int unsigned Rep     = 5;
`ifdef KEY_REPEAT_EN
  localparam bit RepEn = 1'b1;
`else
  localparam bit RepEn = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic [3:0]  Row_Sig;
  logic [3:0]  Col_Sig;
  logic        Key_Valid;
  logic [3:0]  Key_Code;
  logic [23:0] Number_Sig;
  logic        Number_Done;

  key_scan_entry #(
    .SCAN_DIV    (ScanDiv),
    .DEBOUNCE_CNT(Deb),
    .REPEAT_TICKS(Rep)
  ) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .Row_Sig    (Row_Sig),
    .Col_Sig    (Col_Sig),
    .Key_Valid  (Key_Valid),
    .Key_Code   (Key_Code),
    .Number_Sig (Number_Sig),
    .Number_Done(Number_Done)
  );

  always #5 CLK = ~CLK;

  // Keypad: key index = row*4 + col; a pressed key pulls its row low when its column is driven.
  logic [15:0] keys = '0;
  always_comb begin
    Row_Sig = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !Col_Sig[c]) Row_Sig[r] = 1'b0;
      end
    end
  end

  int n_assert = 0;
  int n_fail   = 0;
  int ev_cnt   = 0;
  int done_cnt = 0;
  int dbl_cnt  = 0;
  logic kv_prev = 1'b0;
  logic nd_prev = 1'b0;

  always @(negedge CLK) begin
    if (Key_Valid) ev_cnt <= ev_cnt + 1;
    if (Number_Done) done_cnt <= done_cnt + 1;
    if ((Key_Valid && kv_prev) || (Number_Done && nd_prev)) dbl_cnt <= dbl_cnt + 1;
    kv_prev <= Key_Valid;
    nd_prev <= Number_Done;
  end

  // Reference model: the entered number as a plain decimal integer.
  int model_num = 0;

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model_apply(input logic [3:0] code);
    if (code <= 4'h9) model_num = (model_num * 10 + int'(code)) % 1000000;
    else if (code == 4'hA) model_num = 0;
    else if (code == 4'hB) model_num = model_num / 10;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_kv(output bit got);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK); #1;
      if (Key_Valid) begin
        got = 1'b1;
        return;
      end
    end
  endtask

  // Wait for a tick edge that selects column 0 (scanner must be idle).
  task automatic align_col0();
    for (int i = 0; i < 64 && Col_Sig == 4'b1110; i++) begin
      @(posedge CLK); #1;
    end
    for (int i = 0; i < 64 && Col_Sig != 4'b1110; i++) begin
      @(posedge CLK); #1;
    end
  endtask

  // Press keys in mask, hold for extra ticks past acceptance, release and check the outcome.
  task automatic press(input logic [15:0] mask, input logic [3:0] code, input int extra,
                       input string tag);
    int ev0, done0, nrep;
    bit got;
    ev0   = ev_cnt;
    done0 = done_cnt;
    keys  = mask;
    wait_kv(got);
    check({tag, " accepted"}, 32'(got), 32'd1);
    repeat (4 * extra) @(posedge CLK);
    #1;
    keys = '0;
    repeat (4 * 8) @(posedge CLK);
    #1;
    nrep = (RepEn && code != 4'hA && code != 4'hE) ? extra / Rep : 0;
    for (int k = 0; k <= nrep; k++) model_apply(code);
    check({tag, " events"}, 32'(ev_cnt - ev0), 32'(nrep + 1));
    check({tag, " code"}, 32'(Key_Code), 32'(code));
    check({tag, " number"}, 32'(Number_Sig), 32'(to_bcd(model_num)));
    check({tag, " done"}, 32'(done_cnt - done0), (code == 4'hE) ? 32'd1 : 32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] col_exp;
    int ev0;
    int code;

    // Reset values.
    repeat (3) @(posedge CLK);
    #1;
    check("rst col", 32'(Col_Sig), 32'h0000000E);
    check("rst valid", 32'(Key_Valid), 32'd0);
    check("rst code", 32'(Key_Code), 32'd0);
    check("rst number", 32'(Number_Sig), 32'd0);
    check("rst done", 32'(Number_Done), 32'd0);
    RSTn = 1'b1;

    // Idle scan: one column step per ScanDiv clocks.
    for (int i = 0; i < 16 && Col_Sig == 4'b1110; i++) begin
      @(posedge CLK); #1;
    end
    col_exp = 4'b1101;
    check("scan first step", 32'(Col_Sig), 32'(col_exp));
    for (int s = 0; s < 4; s++) begin
      repeat (ScanDiv - 1) @(posedge CLK);
      #1;
      check("scan hold", 32'(Col_Sig), 32'(col_exp));
      @(posedge CLK); #1;
      col_exp = {col_exp[2:0], col_exp[3]};
      check("scan step", 32'(Col_Sig), 32'(col_exp));
    end
    check("scan no events", 32'(ev_cnt), 32'd0);
    check("scan number", 32'(Number_Sig), 32'd0);

    // Row1/col2 held ~10 ticks.
    press(16'h0040, 4'h6, 7, "key6");
    check("key6 value", 32'(Number_Sig), RepEn ? 32'h000066 : 32'h000006);

    // Bounce on row0/col0, then a proper hold.
    align_col0();
    ev0  = ev_cnt;
    keys = 16'h0001;
    repeat (4) @(posedge CLK);
    #1 keys = '0;
    repeat (4) @(posedge CLK);
    #1 keys = 16'h0001;
    repeat (4) @(posedge CLK);
    #1 keys = '0;
    repeat (4) @(posedge CLK);
    #1;
    check("bounce no event", 32'(ev_cnt), 32'(ev0));
    press(16'h0001, 4'h0, 0, "bounce hold");

    // Digit entry with wrap, backspace, enter, clear.
    for (int d = 1; d <= 7; d++) press(16'(1 << d), 4'(d), 0, "digit");
    check("seq 1..7", 32'(Number_Sig), 32'h00234567);
    press(16'h0800, 4'hB, 0, "backspace");
    check("seq bksp", 32'(Number_Sig), 32'h00023456);
    press(16'h4000, 4'hE, 0, "enter");
    check("seq enter", 32'(Number_Sig), 32'h00023456);
    press(16'h0400, 4'hA, 0, "clear");
    check("seq clear", 32'(Number_Sig), 32'd0);

    // Rows 1 and 3 low together on column 0: lower row wins.
    press(16'h1010, 4'h4, 0, "two rows");

    // Reset during debounce.
    align_col0();
    ev0  = ev_cnt;
    keys = 16'h0010;
    repeat (6) @(posedge CLK);
    #1 RSTn = 1'b0;
    #1;
    check("mid rst col", 32'(Col_Sig), 32'h0000000E);
    check("mid rst valid", 32'(Key_Valid), 32'd0);
    check("mid rst code", 32'(Key_Code), 32'd0);
    check("mid rst number", 32'(Number_Sig), 32'd0);
    check("mid rst done", 32'(Number_Done), 32'd0);
    keys = '0;
    repeat (3) @(posedge CLK);
    #1 RSTn = 1'b1;
    model_num = 0;
    repeat (4 * 20) @(posedge CLK);
    #1;
    check("post rst no event", 32'(ev_cnt), 32'(ev0));
    check("post rst number", 32'(Number_Sig), 32'd0);

    // Randomized keys against the model.
    for (int i = 0; i < 24; i++) begin
      code = int'($urandom_range(0, 15));
      press(16'(1 << code), 4'(code), int'($urandom_range(0, 3)), "random");
    end

`ifdef KEY_REPEAT_EN
    press(16'h0400, 4'hA, 16, "repeat clear");
    press(16'h0200, 4'h9, 16, "repeat nine");
    check("repeat value", 32'(Number_Sig), 32'h00009999);
`endif

    check("single-cycle pulses", 32'(dbl_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
